// File: rtl/gyro_pkg.sv
// rtl/gyro_pkg.sv - shared types and rate limits for the gyro bias calibrator
package gyro_pkg;

   typedef enum logic {
      CAL = 1'b0,
      RUN = 1'b1
   } gyro_state_t;

   typedef logic signed [15:0] gyro_rate_t;

   localparam int RATE_MAX = 32767;
   localparam int RATE_MIN = -32768;

endpackage

// File: rtl/gyro_axis_corr.sv
// rtl/gyro_axis_corr.sv - one-axis bias subtract, saturate and deadband, two pipeline stages
module gyro_axis_corr
   import gyro_pkg::*;
#(
   parameter int unsigned DEADBAND = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        sample_valid,
   input  logic [15:0] sample,
   input  logic [15:0] bias,
   output logic [15:0] rate,
   output logic        rate_valid
);

   localparam logic signed [16:0] SAT_HI = 17'(RATE_MAX);
   localparam logic signed [16:0] SAT_LO = 17'(RATE_MIN);
   localparam logic signed [16:0] DB_HI  = 17'(DEADBAND);
   localparam logic signed [16:0] DB_LO  = -DB_HI;

   logic signed [16:0] diff;
   gyro_rate_t         sat;
   gyro_rate_t         s1_rate;
   logic               s1_valid;
   logic signed [16:0] s1_ext;
   logic               in_band;

   always_comb begin
      diff = {sample[15], sample} - {bias[15], bias};
      if (diff > SAT_HI) begin
         sat = 16'(RATE_MAX);
      end else if (diff < SAT_LO) begin
         sat = 16'(RATE_MIN);
      end else begin
         sat = diff[15:0];
      end
   end

   // Compare in 17 bits so -32768 never needs an absolute value
   assign s1_ext  = {s1_rate[15], s1_rate};
   assign in_band = (s1_ext >= DB_LO) && (s1_ext <= DB_HI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_rate    <= '0;
         s1_valid   <= 1'b0;
         rate       <= '0;
         rate_valid <= 1'b0;
      end else if (flush) begin
         s1_valid   <= 1'b0;
         rate_valid <= 1'b0;
      end else begin
         s1_valid   <= sample_valid;
         rate_valid <= s1_valid;
         if (sample_valid) begin
            s1_rate <= sat;
         end
         if (s1_valid) begin
            rate <= in_band ? 16'd0 : s1_rate;
         end
      end
   end

endmodule

// File: rtl/gyro_bias_cal.sv
// rtl/gyro_bias_cal.sv - zero-rate bias calibration FSM and three-axis correction top
module gyro_bias_cal
   import gyro_pkg::*;
#(
   parameter int unsigned CAL_LOG2 = 8,
   parameter int unsigned DEADBAND = 16
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        recal_in,
   input  logic        sample_valid_in,
   input  logic [15:0] gx_in,
   input  logic [15:0] gy_in,
   input  logic [15:0] gz_in,
   output logic [15:0] gx_out,
   output logic [15:0] gy_out,
   output logic [15:0] gz_out,
   output logic        valid_out,
   output logic        calibrated_out,
   output logic [15:0] bias_x_out,
   output logic [15:0] bias_y_out,
   output logic [15:0] bias_z_out
);

   localparam int unsigned ACC_W = 16 + CAL_LOG2;
   localparam logic [CAL_LOG2:0] CAL_N = {1'b1, {CAL_LOG2{1'b0}}};

   gyro_state_t               state;
   logic [CAL_LOG2:0]         cnt;
   logic [CAL_LOG2:0]         cnt_next;
   logic                      last_sample;
   logic                      run_sample;
   logic [15:0]               raw       [3];
   logic signed [ACC_W-1:0]   acc       [3];
   logic signed [ACC_W-1:0]   sum       [3];
   logic [15:0]               bias      [3];
   logic [15:0]               bias_next [3];
   logic                      vx, vy, vz;

   assign raw[0] = gx_in;
   assign raw[1] = gy_in;
   assign raw[2] = gz_in;

   always_comb begin
      cnt_next    = cnt + 1'b1;
      last_sample = (cnt_next == CAL_N);
      for (int i = 0; i < 3; i++) begin
         sum[i]       = acc[i] + ACC_W'($signed(raw[i]));
         bias_next[i] = 16'(sum[i] >>> CAL_LOG2);
      end
   end

   // Recal outranks a coincident sample; bias registers only change on completion
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= CAL;
         cnt   <= '0;
         for (int i = 0; i < 3; i++) begin
            acc[i]  <= '0;
            bias[i] <= '0;
         end
      end else if (recal_in) begin
         state <= CAL;
         cnt   <= '0;
         for (int i = 0; i < 3; i++) begin
            acc[i] <= '0;
         end
      end else if (state == CAL && sample_valid_in) begin
         if (last_sample) begin
            state <= RUN;
            cnt   <= '0;
            for (int i = 0; i < 3; i++) begin
               acc[i]  <= '0;
               bias[i] <= bias_next[i];
            end
         end else begin
            cnt <= cnt_next;
            for (int i = 0; i < 3; i++) begin
               acc[i] <= sum[i];
            end
         end
      end
   end

   assign run_sample     = (state == RUN) && sample_valid_in && !recal_in;
   assign calibrated_out = (state == RUN);
   assign bias_x_out     = bias[0];
   assign bias_y_out     = bias[1];
   assign bias_z_out     = bias[2];

   gyro_axis_corr #(.DEADBAND(DEADBAND)) u_corr_x (
      .clk          (clk_in),
      .rst_n        (rst_n_in),
      .flush        (recal_in),
      .sample_valid (run_sample),
      .sample       (gx_in),
      .bias         (bias[0]),
      .rate         (gx_out),
      .rate_valid   (vx)
   );

   gyro_axis_corr #(.DEADBAND(DEADBAND)) u_corr_y (
      .clk          (clk_in),
      .rst_n        (rst_n_in),
      .flush        (recal_in),
      .sample_valid (run_sample),
      .sample       (gy_in),
      .bias         (bias[1]),
      .rate         (gy_out),
      .rate_valid   (vy)
   );

   gyro_axis_corr #(.DEADBAND(DEADBAND)) u_corr_z (
      .clk          (clk_in),
      .rst_n        (rst_n_in),
      .flush        (recal_in),
      .sample_valid (run_sample),
      .sample       (gz_in),
      .bias         (bias[2]),
      .rate         (gz_out),
      .rate_valid   (vz)
   );

   // The three axis pipelines share one valid sequence
   assign valid_out = vx & vy & vz;

endmodule

// File: doc/gyro_bias_cal.md
# gyro_bias_cal

Calibrates and corrects raw three-axis gyroscope rate samples before integration into pitch/roll/yaw. After reset, or on request, it averages 2^CAL_LOG2 stationary samples per axis to estimate zero-rate bias. It then streams bias-subtracted, saturated, dead-banded samples with a valid strobe. It sits between the MPU-6050 reader and the gyro-processing stage, on the 100 MHz system clock.

## Interface
- CAL_LOG2, 8, log2 of the calibration sample count; legal range 1..12.
- DEADBAND, 16, corrected magnitudes of DEADBAND or less are forced to 0; unsigned, less than 32768.
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- recal_in  input  1  single-cycle request to restart calibration.
- sample_valid_in  input  1  gx/gy/gz_in hold a new sample this cycle; synchronous to clk_in, and CDC is the producer's job.
- gx_in, gy_in, gz_in  input  16 each  raw signed rates.
- gx_out, gy_out, gz_out  output  16 each  corrected signed rates.
- valid_out  output  1  one-cycle strobe, corrected sample present.
- calibrated_out  output  1  high while in RUN.
- bias_x_out, bias_y_out, bias_z_out  output  16 each  current signed bias estimates.

## Operation
- States: CAL and RUN. Reset enters CAL.
- CAL:
  - Each sample_valid_in adds the sign-extended sample to a per-axis accumulator of 16+CAL_LOG2 bits, and increments a CAL_LOG2+1-bit counter.
  - When the counter reaches 2^CAL_LOG2, bias = accumulator >>> CAL_LOG2, an arithmetic shift that floors toward minus infinity.
  - The state then becomes RUN and calibrated_out rises on the same edge that loads the bias.
  - No valid_out is produced in CAL.
- RUN, per axis and per valid sample:
  - Compute d = sample - bias in 17 bits.
  - Saturate d to [-32768, 32767].
  - If |d| <= DEADBAND, output 0; otherwise output d.
- recal_in, in any state:
  - On the next edge, clear the accumulators and counter, enter CAL, drop calibrated_out, and flush pipeline valids so no valid_out follows.
  - Bias outputs hold their old values until the new calibration completes.
- recal_in together with sample_valid_in: recal wins and the sample is discarded.
- Reset mid-operation: all state returns to its reset values immediately, because reset is asynchronous.
- Reset values: every data output, bias output and accumulator is 0; valid_out is 0; calibrated_out is 0; the state is CAL.

## Timing
- RUN pipeline has two stages:
  - stage 1 registers the saturated difference;
  - stage 2 registers the dead-banded result and valid_out.
- valid_out asserts exactly 2 cycles after the sample_valid_in that produced it.
- gx/gy/gz_out hold their values until the next valid_out.
- Back-to-back sample_valid_in every cycle is supported at full throughput, with no backpressure.
- The CAL-to-RUN transition occurs on the edge that accepts the 2^CAL_LOG2-th sample.
- The first RUN sample can be accepted on the following cycle.
- The final calibration sample is never passed to the output.

## Structure
- gyro_pkg holds:
  - typedef gyro_state_t, an enum {CAL, RUN};
  - typedef gyro_rate_t, logic signed [15:0];
  - constants RATE_MAX = 32767 and RATE_MIN = -32768.
- Sub-module gyro_axis_corr handles one axis: subtract, saturate, deadband, and the two pipeline registers.
  - It is instantiated three times.
  - The top of gyro_bias_cal holds the FSM, counter, accumulators and bias registers.

## Test plan
Bench uses CAL_LOG2=2 and DEADBAND=16.
- Calibration: gx samples 10, 12, 14, 16 -> bias_x_out = 13 and calibrated_out = 1 after the 4th sample. Then gx = 100 -> gx_out = 87 with valid_out exactly 2 cycles later.
- Negative floor and deadband: gy samples -1, -1, -1, -2 -> bias_y_out = -2. Then gy = 14 -> 16 -> gy_out = 0. Then gy = 15 -> gy_out = 17.
- Saturation: gz bias 100 from four samples of 100. Then gz = -32768 -> gz_out = -32768. With bias -100, gz = 32767 -> gz_out = 32767.
- Streaming: 10 consecutive sample_valid_in cycles in RUN -> 10 consecutive valid_out cycles, in order, each lagging by 2 cycles.
- Recalibration: recal_in in RUN, asserted together with a sample_valid_in while 2 samples are in flight:
  - no valid_out follows and calibrated_out drops the next cycle;
  - the coincident sample is not counted, so 4 further samples are needed;
  - the old bias is held until the new bias loads.
- Async reset: rst_n_in low mid-CAL after 2 samples, released -> all outputs 0, and 4 fresh samples are required before calibrated_out rises.
